// File: rtl/sdio_data_ctrl_pkg.sv
// SDIO data-path controller shared types and constants.
// State encoding and default timing used by the controller and its FIFO.
package sdio_data_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVATE,
    S_XFER,
    S_CRC_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  localparam int MAX_BLOCK_SIZE = 512;
  localparam int DEF_CRC_WAIT   = 12;
  localparam int DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/sdio_byte_fifo.sv
// Byte-wide skid FIFO for the host-to-card path.
// Push when full and pop when empty are ignored; flush empties it.
module sdio_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdio_data_ctrl.sv
// SDIO block data-transfer controller between phy and client.
// SDIO_DATA_CTRL_CRC_STATS_EN enables the CRC error counter.
module sdio_data_ctrl
  import sdio_data_ctrl_pkg::*;
#(
  parameter int CRC_WAIT   = DEF_CRC_WAIT,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_xfer_start,
  input  logic        i_xfer_write,
  input  logic [9:0]  i_block_size,
  input  logic [8:0]  i_block_count,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_crc_err,
  output logic        o_overrun,
  output logic [8:0]  o_blocks_done,
  output logic [15:0] o_crc_err_count,
  output logic        o_phy_activate,
  output logic        o_phy_write_flag,
  output logic [9:0]  o_phy_data_count,
  input  logic        i_phy_wr_stb,
  input  logic [7:0]  i_phy_wr_data,
  output logic        o_phy_rd_stb,
  output logic [7:0]  o_phy_rd_data,
  input  logic        i_phy_hst_rdy,
  output logic        o_phy_com_rdy,
  input  logic        i_phy_crc_good,
  output logic        o_wr_stb,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_ready,
  input  logic        i_rd_valid,
  input  logic [7:0]  i_rd_data,
  output logic        o_rd_ack
);

  localparam int BW = $clog2(MAX_BLOCK_SIZE + 1);
  localparam logic [15:0] CRC_LAST = 16'(CRC_WAIT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t        state, state_nxt;
  logic          wr_q, wr_nxt;
  logic [BW-1:0] size_q, size_nxt;
  logic [8:0]    count_q, count_nxt;
  logic [BW-1:0] byte_cnt, byte_nxt;
  logic [15:0]   wait_cnt, wait_nxt;
  logic [15:0]   gap_cnt, gap_nxt;
  logic          done_q, done_nxt;
  logic          crc_err_q, crc_err_nxt;
  logic          ovr_q, ovr_nxt;
  logic [8:0]    blocks_q, blocks_nxt;
  logic          rd_stb_q, rd_stb_nxt;
  logic [7:0]    rd_data_q, rd_data_nxt;

  logic       act, aborting, last_byte;
  logic       rd_take, fifo_push;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  assign aborting  = i_abort && (state != S_IDLE);
  assign act       = (state == S_ACTIVATE) ||
                     (state == S_XFER) ||
                     (state == S_CRC_WAIT);
  assign last_byte = (byte_cnt == size_q - 1'b1);
  assign rd_take   = (state == S_XFER) && !wr_q &&
                     i_rd_valid && i_phy_hst_rdy && !i_abort;
  assign fifo_push = (state == S_XFER) && wr_q &&
                     i_phy_wr_stb && !i_abort;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      size_q    <= '0;
      count_q   <= '0;
      byte_cnt  <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      ovr_q     <= 1'b0;
      blocks_q  <= '0;
      rd_stb_q  <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state     <= state_nxt;
      wr_q      <= wr_nxt;
      size_q    <= size_nxt;
      count_q   <= count_nxt;
      byte_cnt  <= byte_nxt;
      wait_cnt  <= wait_nxt;
      gap_cnt   <= gap_nxt;
      done_q    <= done_nxt;
      crc_err_q <= crc_err_nxt;
      ovr_q     <= ovr_nxt;
      blocks_q  <= blocks_nxt;
      rd_stb_q  <= rd_stb_nxt;
      rd_data_q <= rd_data_nxt;
    end
  end

  // Next-state and pulse generation; abort overrides everything.
  always_comb begin
    state_nxt   = state;
    wr_nxt      = wr_q;
    size_nxt    = size_q;
    count_nxt   = count_q;
    byte_nxt    = byte_cnt;
    wait_nxt    = wait_cnt;
    gap_nxt     = gap_cnt;
    done_nxt    = 1'b0;
    crc_err_nxt = 1'b0;
    ovr_nxt     = ovr_q;
    blocks_nxt  = blocks_q;
    rd_stb_nxt  = 1'b0;
    rd_data_nxt = rd_data_q;
    unique case (state)
      S_IDLE: begin
        if (i_xfer_start && !i_abort) begin
          wr_nxt     = i_xfer_write;
          size_nxt   = i_block_size;
          count_nxt  = i_block_count;
          blocks_nxt = '0;
          ovr_nxt    = 1'b0;
          if (i_block_size == '0) begin
            done_nxt    = 1'b1;
            crc_err_nxt = 1'b1;
          end else begin
            state_nxt = S_ACTIVATE;
          end
        end
      end
      S_ACTIVATE: begin
        byte_nxt  = '0;
        state_nxt = S_XFER;
      end
      S_XFER: begin
        if (fifo_push || rd_take) begin
          byte_nxt = byte_cnt + 1'b1;
          if (last_byte) begin
            wait_nxt  = '0;
            state_nxt = S_CRC_WAIT;
          end
        end
        if (fifo_push && fifo_full) ovr_nxt = 1'b1;
        if (rd_take) begin
          rd_stb_nxt  = 1'b1;
          rd_data_nxt = i_rd_data;
        end
      end
      S_CRC_WAIT: begin
        if (wait_cnt == CRC_LAST) begin
          crc_err_nxt = !i_phy_crc_good;
          blocks_nxt  = blocks_q + 1'b1;
          gap_nxt     = '0;
          state_nxt   = S_GAP;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (count_q == '0 || blocks_q != count_q) begin
            state_nxt = S_ACTIVATE;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (aborting) begin
      state_nxt   = S_IDLE;
      done_nxt    = 1'b1;
      crc_err_nxt = 1'b0;
      blocks_nxt  = blocks_q;
      rd_stb_nxt  = 1'b0;
    end
  end

  sdio_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (aborting),
    .push  (fifo_push),
    .din   (i_phy_wr_data),
    .pop   (i_wr_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SDIO_DATA_CTRL_CRC_STATS_EN
  logic [15:0] crc_cnt;
  logic        crc_bump;

  assign crc_bump = (state == S_CRC_WAIT) &&
                    (wait_cnt == CRC_LAST) &&
                    !i_phy_crc_good && !i_abort;

  // Saturating count of blocks that ended with a bad CRC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_cnt <= '0;
    end else if (crc_bump && crc_cnt != 16'hFFFF) begin
      crc_cnt <= crc_cnt + 1'b1;
    end
  end

  assign o_crc_err_count = crc_cnt;
`else
  assign o_crc_err_count = 16'h0000;
`endif

  assign o_busy           = (state != S_IDLE);
  assign o_done           = done_q;
  assign o_crc_err        = crc_err_q;
  assign o_overrun        = ovr_q;
  assign o_blocks_done    = blocks_q;
  assign o_phy_activate   = act;
  assign o_phy_write_flag = act && wr_q;
  assign o_phy_data_count = act ? size_q : '0;
  assign o_phy_rd_stb     = rd_stb_q;
  assign o_phy_rd_data    = rd_data_q;
  assign o_phy_com_rdy    = (state == S_XFER) && !wr_q && i_rd_valid;
  assign o_rd_ack         = rd_take;
  assign o_wr_stb         = !fifo_empty && i_wr_ready;
  assign o_wr_data        = o_wr_stb ? fifo_dout : 8'h00;

endmodule

// File: doc/sdio_data_ctrl.md
SDIO_DATA_CTRL -- requirements
Module: sdio_data_ctrl

Interface
REQ-001 SHALL have parameter CRC_WAIT, default 12, cycles from last data byte to sampling i_phy_crc_good.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, cycles o_phy_activate is held low between blocks.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write-path skid FIFO depth in bytes (power of 2).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 i_xfer_start in 1 (start pulse); i_xfer_write in 1 (1 = host-to-card); i_block_size in 10 (bytes per block, 1..512); i_block_count in 9 (0 = unbounded); i_abort in 1 (abort pulse).
REQ-007 o_busy out 1; o_done out 1 (pulse); o_crc_err out 1 (pulse); o_overrun out 1 (sticky); o_blocks_done out 9; o_crc_err_count out 16.
REQ-008 Phy side: o_phy_activate out 1; o_phy_write_flag out 1; o_phy_data_count out 10; i_phy_wr_stb in 1; i_phy_wr_data in 8; o_phy_rd_stb out 1; o_phy_rd_data out 8; i_phy_hst_rdy in 1; o_phy_com_rdy out 1; i_phy_crc_good in 1.
REQ-009 Client side: o_wr_stb out 1, o_wr_data out 8, i_wr_ready in 1 (write sink); i_rd_valid in 1, i_rd_data in 8, o_rd_ack out 1 (read source).

Function
REQ-010 States: IDLE, ACTIVATE, XFER, CRC_WAIT, GAP, DONE.
REQ-011 IDLE: on i_xfer_start, latch write/size/count, clear o_blocks_done and o_overrun, go to ACTIVATE; i_xfer_start outside IDLE is ignored.
REQ-012 i_block_size == 0 at start: no transfer; o_done and o_crc_err pulse together the next cycle.
REQ-013 ACTIVATE: assert o_phy_activate, o_phy_write_flag = latched write, o_phy_data_count = latched size; go to XFER the next cycle.
REQ-014 XFER write: count i_phy_wr_stb; push i_phy_wr_data into the FIFO; the size-th strobe moves to CRC_WAIT.
REQ-015 Write FIFO drain: o_wr_stb = FIFO non-empty && i_wr_ready, one byte per cycle; data valid with the strobe.
REQ-016 Push while FIFO full: drop the byte, set o_overrun; the block still completes.
REQ-017 XFER read: o_phy_com_rdy = i_rd_valid; when i_rd_valid && i_phy_hst_rdy && bytes remain, pulse o_rd_ack and o_phy_rd_stb (registered, one cycle later) with o_phy_rd_data = captured i_rd_data; at most one byte per cycle.
REQ-018 The size-th read strobe moves to CRC_WAIT; o_phy_com_rdy is 0 outside XFER.
REQ-019 CRC_WAIT: count CRC_WAIT cycles, then sample i_phy_crc_good; on 0, pulse o_crc_err and increment o_crc_err_count (saturates at 16'hFFFF).
REQ-020 After CRC_WAIT, increment o_blocks_done (9-bit wrap permitted only when count = 0); deassert o_phy_activate; go to GAP.
REQ-021 GAP: hold activate low GAP_CYCLES; then ACTIVATE if blocks remain (or count = 0), else DONE.
REQ-022 A CRC error does not stop a multi-block transfer.
REQ-023 DONE: pulse o_done for one cycle, return to IDLE.
REQ-024 i_abort in any non-IDLE state: deassert o_phy_activate, flush the FIFO, pulse o_done the next cycle, go to IDLE; o_blocks_done keeps the completed-block count.
REQ-025 i_abort coincident with i_xfer_start in IDLE: abort wins, no transfer.
REQ-026 o_busy = 1 in every state except IDLE.

Reset
REQ-027 rst low at a clock edge: state IDLE; all outputs 0 (o_phy_rd_data = 8'h00, o_blocks_done = 0, o_crc_err_count = 0); FIFO empty.
REQ-028 Reset mid-transfer drops o_phy_activate the cycle after the sampled edge; no o_done pulse.

Configuration
REQ-029 Macro SDIO_DATA_CTRL_CRC_STATS_EN defined: o_crc_err_count behaves per REQ-019.
REQ-030 Macro undefined: o_crc_err_count tied to 16'h0000, no counter flops; o_crc_err is unchanged.

Structure
REQ-031 Shared package sdio_data_ctrl_pkg: state encoding, MAX_BLOCK_SIZE = 512, default CRC_WAIT/GAP_CYCLES constants.
REQ-032 Write-path FIFO SHALL be sub-module sdio_byte_fifo (push/pop/full/empty/flush, depth parameter).

Verification
REQ-033 Write, size 4, count 1, strobes carry 0x11,0x22,0x33,0x44, crc_good = 1, wr_ready = 1 -> o_wr_stb delivers 0x11..0x44 in order; o_blocks_done = 1; o_done pulses once; no o_crc_err.
REQ-034 Read, size 3, count 2, source 0xA0..0xA5 always valid, hst_rdy = 1 -> six o_phy_rd_stb with 0xA0..0xA5; activate low for exactly 2 cycles between blocks; o_blocks_done = 2.
REQ-035 Write, size 8, wr_ready = 0 throughout -> 4 bytes buffered, o_overrun = 1, block completes, o_done pulses.
REQ-036 Read, size 2, count 3, crc_good = 0 on block 2 -> exactly one o_crc_err; o_crc_err_count = 1 (macro defined) or 0 (undefined); o_blocks_done = 3.
REQ-037 Count 0 (unbounded), abort after the 5th block's ACTIVATE -> activate low the next cycle, o_done pulse, o_blocks_done = 4.
REQ-038 rst low during XFER of a size-16 read -> o_phy_activate = 0, o_busy = 0 after the edge, no o_done pulse.
